// File: rtl/mands_frame_ctrl.sv
// Frame sequencer for the MandS running max/sum datapath: groups the sample
// stream into FRAME_LEN-sample frames and hands each frame's Max/Sum to a consumer.
module mands_frame_ctrl #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        en,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mands_start,
  output logic        mands_valid,
  output logic [7:0]  mands_data,
  input  logic [7:0]  mands_max,
  input  logic [11:0] mands_sum,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_max,
  output logic [11:0] res_sum,
  output logic [7:0]  res_count,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] ACCUM  = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
  localparam logic [2:0] REPORT = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_res_valid;
  logic [7:0]       r_res_max;
  logic [11:0]      r_res_sum;
  logic [7:0]       r_res_count;
  logic             w_acc;
  logic             w_last;
  logic             w_abort;
  logic [2:0]       w_exit;

  // Both handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; valid and its payload stay stable until that edge.
  assign in_ready    = (r_state == ACCUM) && !abort;
  assign w_acc       = in_valid && in_ready;
  assign w_last      = (r_cnt == CNT_W'(FRAME_LEN - 1));
  assign w_abort     = abort && (r_state != IDLE);
  assign w_exit      = en ? CLEAR : IDLE;

  assign mands_start = (r_state == IDLE) || (r_state == CLEAR);
  assign mands_valid = w_acc;
  assign mands_data  = w_acc ? in_data : 8'h00;

  assign res_valid   = r_res_valid;
  assign res_max     = r_res_max;
  assign res_sum     = r_res_sum;
  assign res_count   = r_res_count;
  assign busy        = (r_state != IDLE);
  assign dbg_state   = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (en) w_next = CLEAR;
      CLEAR:   w_next = abort ? w_exit : ACCUM;
      ACCUM: begin
        if (abort)               w_next = w_exit;
        else if (w_acc && w_last) w_next = DONE;
      end
      DONE:    w_next = abort ? w_exit : REPORT;
      REPORT: begin
        if (abort)          w_next = w_exit;
        else if (res_ready) w_next = w_exit;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_res_max   <= 8'h80;
      r_res_sum   <= 12'h000;
      r_res_count <= 8'h00;
    end else begin
      r_state <= w_next;
      if (w_abort) begin
        r_cnt       <= '0;
        r_res_valid <= 1'b0;
      end else begin
        case (r_state)
          CLEAR: r_cnt <= '0;
          ACCUM: if (w_acc) r_cnt <= r_cnt + 1'b1;
          DONE: begin
            // Datapath outputs now include the final sample of the frame.
            r_res_max   <= mands_max;
            r_res_sum   <= mands_sum;
            r_res_valid <= 1'b1;
          end
          REPORT: begin
            if (res_ready) begin
              r_res_valid <= 1'b0;
              r_res_count <= r_res_count + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mands_frame_ctrl.sv
// Bench for mands_frame_ctrl: a behavioural max/sum datapath closes the loop and
// a result scoreboard compares every frame result against values computed here.
module tb_mands_frame_ctrl;

  localparam int FL = 16;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_ACCUM  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        en = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mands_start;
  logic        mands_valid;
  logic [7:0]  mands_data;
  logic [7:0]  dp_max = 8'h80;
  logic [11:0] dp_sum = 12'h000;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [7:0]  res_max;
  logic [11:0] res_sum;
  logic [7:0]  res_count;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [19:0] exp_q[$];
  logic [7:0]  frame_buf[FL];

  mands_frame_ctrl #(.FRAME_LEN(FL), .CNT_W(5)) dut (
    .clk(clk), .resetb(resetb), .en(en), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mands_start(mands_start), .mands_valid(mands_valid), .mands_data(mands_data),
    .mands_max(dp_max), .mands_sum(dp_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_max(res_max),
    .res_sum(res_sum), .res_count(res_count), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural MandS datapath: registered running max and sum, cleared by start.
  always @(posedge clk) begin
    if (mands_start) begin
      dp_max <= 8'h80;
      dp_sum <= 12'h000;
    end else if (mands_valid) begin
      if ($signed(mands_data) > $signed(dp_max)) dp_max <= mands_data;
      dp_sum <= dp_sum + {{4{mands_data[7]}}, mands_data};
    end
  end

  // Scoreboard and protocol watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (resetb) begin
      n_cmp++;
      if (mands_valid && !in_ready) begin
        n_fail++;
        $display("FAIL mands_valid_wo_ready: mands_valid=1 in_ready=0 t=%0t", $time);
      end
      n_cmp++;
      if (in_ready && dbg_state != S_ACCUM) begin
        n_fail++;
        $display("FAIL in_ready_state: in_ready=1 in state %0d t=%0t", dbg_state, $time);
      end
      if (res_valid && res_ready && !abort) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL result_unexpected: got max=%h sum=%h, none expected", res_max, res_sum);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          if ({res_max, res_sum} !== e) begin
            n_fail++;
            $display("FAIL result: got max=%h sum=%h, want max=%h sum=%h",
                     res_max, res_sum, e[19:12], e[11:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [7:0] d, input int gap);
    bit done;
    done = 1'b0;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 200 && !done; k++) begin
      #1;
      if (in_ready) begin
        n_cmp++;
        if (mands_valid !== 1'b1 || mands_data !== d) begin
          n_fail++;
          $display("FAIL mands_drive: valid=%b data=%h, want valid=1 data=%h", mands_valid, mands_data, d);
        end
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=0, want 1 within 200 cycles");
    end
  endtask

  task automatic send_frame(input bit gaps, input bit push);
    int mx, sm;
    mx = -128;
    sm = 0;
    for (int i = 0; i < FL; i++) begin
      if ($signed(frame_buf[i]) > mx) mx = $signed(frame_buf[i]);
      sm += $signed(frame_buf[i]);
    end
    if (push) exp_q.push_back({mx[7:0], sm[11:0]});
    for (int i = 0; i < FL; i++)
      send_sample(frame_buf[i], gaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic wait_res();
    int k;
    k = 0;
    while (!res_valid && k < 50) begin
      tick();
      k++;
    end
    if (!res_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL res_timeout: res_valid=0, want 1 within 50 cycles");
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    tick();
    tick();
    resetb = 1'b1;
    n_cmp++;
    if (dbg_state !== S_IDLE || busy !== 1'b0 || mands_start !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: state=%0d busy=%b start=%b rdy=%b, want 0 0 1 0", dbg_state, busy, mands_start, in_ready);
    end
    n_cmp++;
    if (res_valid !== 1'b0 || res_max !== 8'h80 || res_sum !== 12'h000 || res_count !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_res: v=%b max=%h sum=%h cnt=%h, want 0 80 000 00", res_valid, res_max, res_sum, res_count);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if (dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL abort_idle: state=%0d, want %0d", dbg_state, S_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    en = 1'b1;
    tick();
    n_cmp++;
    if (dbg_state !== S_CLEAR || mands_start !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL first_clear: state=%0d start=%b rdy=%b, want 1 1 0", dbg_state, mands_start, in_ready);
    end
    for (int i = 0; i < FL; i++) frame_buf[i] = 8'(i + 1);
    send_frame(1'b0, 1'b1);
    n_cmp++;
    if (dbg_state !== S_DONE || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_t1: state=%0d res_valid=%b, want 3 0", dbg_state, res_valid);
    end
    tick();
    n_cmp++;
    if (res_valid !== 1'b1 || res_max !== 8'd16 || res_sum !== 12'd136) begin
      n_fail++;
      $display("FAIL latency_t2: v=%b max=%h sum=%h, want 1 10 088", res_valid, res_max, res_sum);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_cmp++;
    if (res_count !== 8'd1 || res_valid !== 1'b0 || dbg_state !== S_CLEAR) begin
      n_fail++;
      $display("FAIL handshake1: cnt=%0d v=%b state=%0d, want 1 0 1", res_count, res_valid, dbg_state);
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < FL; i++) frame_buf[i] = 8'h80;
    send_frame(1'b1, 1'b1);
    wait_res();
    n_cmp++;
    if (res_max !== 8'h80 || res_sum !== 12'h800) begin
      n_fail++;
      $display("FAIL neg_frame: max=%h sum=%h, want 80 800", res_max, res_sum);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0]  hm;
    logic [11:0] hs;
    int mx, sm;
    mx = -128;
    sm = 0;
    for (int i = 0; i < FL; i++) begin
      frame_buf[i] = 8'($urandom_range(0, 100));
      if (int'(frame_buf[i]) > mx) mx = int'(frame_buf[i]);
      sm += int'(frame_buf[i]);
    end
    hm = mx[7:0];
    hs = sm[11:0];
    send_frame(1'b1, 1'b1);
    wait_res();
    in_valid = 1'b1;
    in_data  = 8'h37;
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if (res_valid !== 1'b1 || res_max !== hm || res_sum !== hs || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_c%0d: v=%b max=%h sum=%h rdy=%b, want 1 %h %h 0", c, res_valid, res_max, res_sum, in_ready, hm, hs);
      end
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    in_valid  = 1'b0;
    n_cmp++;
    if (dbg_state !== S_CLEAR || mands_start !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL post_hold_clear: state=%0d start=%b rdy=%b, want 1 1 0", dbg_state, mands_start, in_ready);
    end
    for (int i = 0; i < FL; i++) frame_buf[i] = 8'h9C;
    send_frame(1'b0, 1'b1);
    wait_res();
    n_cmp++;
    if (res_max !== 8'h9C || res_sum !== 12'h9C0) begin
      n_fail++;
      $display("FAIL fresh_frame: max=%h sum=%h, want 9c 9c0", res_max, res_sum);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_abort();
    logic [7:0] cnt0;
    cnt0 = res_count;
    for (int i = 0; i < 5; i++) send_sample(8'd7, 0);
    in_valid = 1'b1;
    in_data  = 8'd99;
    abort    = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || mands_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_accept: rdy=%b mvalid=%b, want 0 0", in_ready, mands_valid);
    end
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (dbg_state !== S_CLEAR || res_count !== cnt0) begin
      n_fail++;
      $display("FAIL abort_state: state=%0d cnt=%0d, want 1 %0d", dbg_state, res_count, cnt0);
    end
    for (int i = 0; i < FL; i++) frame_buf[i] = 8'd2;
    send_frame(1'b0, 1'b1);
    wait_res();
    n_cmp++;
    if (res_max !== 8'd2 || res_sum !== 12'd32) begin
      n_fail++;
      $display("FAIL post_abort: max=%h sum=%h, want 02 020", res_max, res_sum);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_cmp++;
    if (res_count !== cnt0 + 8'd1) begin
      n_fail++;
      $display("FAIL abort_count: cnt=%0d, want %0d", res_count, cnt0 + 8'd1);
    end
  endtask

  task automatic test_en_drop();
    for (int i = 0; i < FL; i++) frame_buf[i] = 8'($urandom_range(0, 255));
    send_frame(1'b1, 1'b1);
    wait_res();
    en = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();
    n_cmp++;
    if (dbg_state !== S_IDLE || busy !== 1'b0 || mands_start !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL en_drop_idle: state=%0d busy=%b start=%b v=%b, want 0 0 1 0", dbg_state, busy, mands_start, res_valid);
    end
    en = 1'b1;
    tick();
    n_cmp++;
    if (dbg_state !== S_CLEAR || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL en_restart: state=%0d busy=%b, want 1 1", dbg_state, busy);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) send_sample(8'd5, 0);
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    n_cmp++;
    if (dbg_state !== S_IDLE || res_valid !== 1'b0 || res_count !== 8'd0 || res_max !== 8'h80 || res_sum !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_accum: state=%0d v=%b cnt=%0d max=%h sum=%h, want 0 0 0 80 000", dbg_state, res_valid, res_count, res_max, res_sum);
    end
    for (int i = 0; i < FL; i++) frame_buf[i] = 8'd9;
    send_frame(1'b0, 1'b0);
    wait_res();
    tick();
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    n_cmp++;
    if (dbg_state !== S_IDLE || res_valid !== 1'b0 || res_count !== 8'd0 || res_max !== 8'h80 || res_sum !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_report: state=%0d v=%b cnt=%0d max=%h sum=%h, want 0 0 0 80 000", dbg_state, res_valid, res_count, res_max, res_sum);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_backpressure();
    test_abort();
    test_en_drop();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d results outstanding, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mands_frame_ctrl.md
Name: mands_frame_ctrl

Overview:
- Frame sequencer for the MandS running max/sum datapath.
- Accepts a signed 8-bit sample stream over a valid/ready handshake and groups it into frames of FRAME_LEN samples.
- Drives the datapath's start/valid/data inputs and captures its Max/Sum at frame end.
- Presents each frame result on an output valid/ready handshake; sits between the upstream sample source and the result consumer.

Parameters:
- FRAME_LEN, 16, samples per frame; legal range 1..16, which keeps the 12-bit sum free of overflow.
- CNT_W, 5, width of the internal sample counter; must satisfy 2^CNT_W > FRAME_LEN.

Ports:
- clk  input  1  system clock, rising edge
- resetb  input  1  synchronous active-low reset
- en  input  1  run enable, sampled in IDLE and on result handshake
- abort  input  1  discard current frame/result
- in_valid  input  1  upstream sample valid
- in_data  input  8  upstream sample, signed two's complement
- in_ready  output  1  controller accepts sample
- mands_start  output  1  to datapath start (clear)
- mands_valid  output  1  to datapath valid
- mands_data  output  8  to datapath data
- mands_max  input  8  from datapath Max
- mands_sum  input  12  from datapath Sum
- res_valid  output  1  frame result valid
- res_ready  input  1  consumer accepts result
- res_max  output  8  captured frame maximum, signed
- res_sum  output  12  captured frame sum, signed
- res_count  output  8  completed-frame counter
- busy  output  1  high in any state except IDLE

Behaviour:
- States: IDLE, CLEAR, ACCUM, DONE, REPORT. All registers update on the rising clk edge.
- Reset (resetb=0 at an edge) forces:
  - state=IDLE, sample counter=0
  - res_valid=0, res_max=8'h80, res_sum=0, res_count=0
- Reset mid-frame or mid-report discards all progress.
- mands_start=1 in IDLE and CLEAR, 0 otherwise. This holds the datapath at Max=-128, Sum=0.
- IDLE: en=1 -> CLEAR; otherwise stay.
- CLEAR: exactly one cycle, then -> ACCUM; counter=0.
- ACCUM:
  - in_ready=1 unless abort=1.
  - Accept is combinational: acc = in_valid & in_ready.
  - mands_valid=acc; mands_data=in_data when acc, else 0.
  - Each acc increments the counter.
  - acc with counter==FRAME_LEN-1 -> DONE.
  - Upstream may stall indefinitely; there is no timeout.
- in_ready=0 and mands_valid=0 in every state other than ACCUM.
- DONE:
  - One cycle; the datapath outputs now include the last sample.
  - On the DONE->REPORT edge: res_max<=mands_max, res_sum<=mands_sum, res_valid<=1.
- Result latency: last sample accepted in cycle T -> DONE in T+1 -> res_valid=1 with values in T+2.
- REPORT:
  - res_valid, res_max and res_sum are held stable until res_ready=1.
  - On handshake: res_valid<=0, res_count<=res_count+1 (wraps 255->0).
  - Next state: CLEAR if en=1, else IDLE.
- en deassertion during CLEAR, ACCUM or DONE does not stop the frame; it is honoured at the REPORT exit.
- abort=1 in CLEAR, ACCUM, DONE or REPORT:
  - Next state CLEAR if en=1, else IDLE.
  - Counter cleared; res_valid<=0; res_count unchanged.
  - In ACCUM, abort has priority over acceptance; the sample is not consumed.
  - In REPORT, abort has priority over res_ready; the result is dropped.
- abort in IDLE: no effect.
- Arithmetic: the controller does no arithmetic on samples. The sum is the datapath's 12-bit two's complement, exact for FRAME_LEN<=16.
- FRAME_LEN=1: ACCUM->DONE on the first accept.

Test Plan:
- Reset, en=1, 16 samples 1..16 back-to-back -> res_valid 2 cycles after the 16th accept; res_max=16, res_sum=136; res_count=1 after res_ready.
- 16 samples of -128 with random in_valid gaps -> res_max=8'h80, res_sum=12'h800 (-2048); in_ready=0 in CLEAR/DONE/REPORT; mands_valid never high without in_ready.
- Hold res_ready=0 for 10 cycles with the next samples waiting -> result stable, in_ready=0 throughout; after the handshake one CLEAR cycle (mands_start=1), then the next frame starts from Max=-128, Sum=0.
- abort after 5 accepted samples (in_valid=1 same cycle) -> that sample not accepted; next frame of sixteen 2s gives res_sum=32, res_max=2; res_count unchanged by the abort.
- en=0 during REPORT handshake -> IDLE, busy=0, mands_start=1; en=1 -> CLEAR on the next edge.
- resetb=0 for one cycle mid-ACCUM and mid-REPORT -> IDLE, res_valid=0, res_count=0, res_max=8'h80, res_sum=0.
